// File: rtl/comparator_sweep_checker_pkg.sv
// Shared types and constants for the comparator sweep checker.
// Flag bit positions follow the {GT, GE, LT, LE, EQ, NE} ordering of flags_in.
package comparator_sweep_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam int unsigned OP_W   = 3;
  localparam int unsigned FLAG_W = 6;
  localparam int unsigned CNT_W  = 7;
  localparam int unsigned HOLD_W = 4;

  localparam int unsigned GT = 5;
  localparam int unsigned GE = 4;
  localparam int unsigned LT = 3;
  localparam int unsigned LE = 2;
  localparam int unsigned EQ = 1;
  localparam int unsigned NE = 0;

  localparam int unsigned PAIR_COUNT = 64;

endpackage

// File: rtl/comparator_sweep_checker_ref.sv
// Golden unsigned 3-bit comparator: produces the flag vector a correct
// comparator under test is expected to drive for operands a and b.
module comparator_ref_model
  import comparator_sweep_checker_pkg::*;
(
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [FLAG_W-1:0] flags
);

  always_comb begin
    flags     = '0;
    flags[GT] = (a >  b);
    flags[GE] = (a >= b);
    flags[LT] = (a <  b);
    flags[LE] = (a <= b);
    flags[EQ] = (a == b);
    flags[NE] = (a != b);
  end

endmodule

// File: rtl/comparator_sweep_checker.sv
// Sweeps all 64 3-bit operand pairs through an external comparator, holding
// each pair for SETTLE_CYCLES+2 cycles and tallying flag mismatches.
module comparator_sweep_checker
  import comparator_sweep_checker_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [FLAG_W-1:0] flags_in,
  output logic [OP_W-1:0]   a_out,
  output logic [OP_W-1:0]   b_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_count,
  output logic [OP_W-1:0]   fail_a,
  output logic [OP_W-1:0]   fail_b
);

  localparam logic [HOLD_W-1:0]      HOLD_LOAD = HOLD_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0]       ERR_MAX   = CNT_W'(PAIR_COUNT);
  localparam logic [2*OP_W-1:0]      LAST_PAIR = (2*OP_W)'(PAIR_COUNT - 1);

  state_t              state;
  state_t              state_next;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                first_fail_seen;
  logic [FLAG_W-1:0]   expected;
  logic                mismatch;
  logic                last_pair;
  logic [CNT_W-1:0]    err_next;

  comparator_ref_model u_ref (
    .a     (a_out),
    .b     (b_out),
    .flags (expected)
  );

  assign mismatch  = (flags_in != expected);
  assign last_pair = ({a_out, b_out} == LAST_PAIR);
  // Saturating tally; 64 is the largest reachable value for one sweep.
  assign err_next  = (mismatch && (err_count < ERR_MAX)) ? err_count + 1'b1 : err_count;
  assign busy      = (state == ST_HOLD) || (state == ST_CHECK);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE,
      ST_DONE:  if (start) state_next = ST_HOLD;
      ST_HOLD:  if (hold_cnt == '0) state_next = ST_CHECK;
      ST_CHECK: state_next = last_pair ? ST_DONE : ST_HOLD;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_out           <= '0;
      b_out           <= '0;
      err_count       <= '0;
      fail_a          <= '0;
      fail_b          <= '0;
      first_fail_seen <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      hold_cnt        <= '0;
    end else begin
      case (state)
        ST_IDLE,
        ST_DONE: begin
          if (start) begin
            a_out           <= '0;
            b_out           <= '0;
            err_count       <= '0;
            fail_a          <= '0;
            fail_b          <= '0;
            first_fail_seen <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            hold_cnt        <= HOLD_LOAD;
          end
        end
        ST_HOLD: begin
          if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
        end
        ST_CHECK: begin
          err_count <= err_next;
          if (mismatch && !first_fail_seen) begin
            first_fail_seen <= 1'b1;
            fail_a          <= a_out;
            fail_b          <= b_out;
          end
          if (last_pair) begin
            done <= 1'b1;
            pass <= (err_next == '0);
          end else begin
            // B is the low half, so one increment walks B inner, A outer.
            {a_out, b_out} <= {a_out, b_out} + 1'b1;
            hold_cnt       <= HOLD_LOAD;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_comparator_sweep_checker.sv
// Bench for comparator_sweep_checker: two instances (settle 2 and settle 0)
// driven by a behavioural comparator with selectable fault injection.
module tb_comparator_sweep_checker;
  import comparator_sweep_checker_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       start_v;
  logic [1:0]       reset_v;
  logic [1:0][5:0]  flags_v;
  logic [1:0][2:0]  a_v;
  logic [1:0][2:0]  b_v;
  logic [1:0]       busy_v;
  logic [1:0]       done_v;
  logic [1:0]       pass_v;
  logic [1:0][6:0]  err_v;
  logic [1:0][2:0]  fa_v;
  logic [1:0][2:0]  fb_v;

  int tests = 0;
  int fails = 0;

  // 0 = correct, 1 = EQ stuck 0, 2 = GT stuck 1, 3 = random per-pair xor mask
  int         mode = 0;
  logic [5:0] mask [64];

  comparator_sweep_checker #(.SETTLE_CYCLES(2)) dut0 (
    .clk(clk), .reset(reset_v[0]), .start(start_v[0]), .flags_in(flags_v[0]),
    .a_out(a_v[0]), .b_out(b_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .pass(pass_v[0]), .err_count(err_v[0]), .fail_a(fa_v[0]), .fail_b(fb_v[0])
  );

  comparator_sweep_checker #(.SETTLE_CYCLES(0)) dut1 (
    .clk(clk), .reset(reset_v[1]), .start(start_v[1]), .flags_in(flags_v[1]),
    .a_out(a_v[1]), .b_out(b_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .pass(pass_v[1]), .err_count(err_v[1]), .fail_a(fa_v[1]), .fail_b(fb_v[1])
  );

  function automatic logic [5:0] ideal(input int a, input int b);
    logic [5:0] f;
    f     = '0;
    f[GT] = a > b;
    f[GE] = a >= b;
    f[LT] = a < b;
    f[LE] = a <= b;
    f[EQ] = a == b;
    f[NE] = a != b;
    return f;
  endfunction

  function automatic logic [5:0] faulted(input int a, input int b);
    logic [5:0] f;
    f = ideal(a, b);
    case (mode)
      1:       f[EQ] = 1'b0;
      2:       f[GT] = 1'b1;
      3:       f = f ^ mask[a*8 + b];
      default: ;
    endcase
    return f;
  endfunction

  always_comb flags_v[0] = faulted(int'(a_v[0]), int'(b_v[0]));
  always_comb flags_v[1] = faulted(int'(a_v[1]), int'(b_v[1]));

  task automatic test_reset();
    reset_v = 2'b11;
    start_v = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      tests++;
      if ({a_v[d], b_v[d], busy_v[d], done_v[d], pass_v[d], err_v[d], fa_v[d], fb_v[d]} !== '0) begin
        fails++;
        $display("FAIL reset_state dut%0d: a=%0d b=%0d busy=%b done=%b pass=%b err=%0d fa=%0d fb=%0d, required all 0",
                 d, a_v[d], b_v[d], busy_v[d], done_v[d], pass_v[d], err_v[d], fa_v[d], fb_v[d]);
      end
    end
    @(negedge clk);
    reset_v = 2'b00;
  endtask

  task automatic run_sweep(input int d, input bit hold_start, input string name);
    int exp_err, exp_fa, exp_fb, exp_cycles, cycles, busy_low;
    bit seen;
    exp_err = 0; exp_fa = 0; exp_fb = 0; seen = 0;
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++)
        if (faulted(a, b) !== ideal(a, b)) begin
          exp_err++;
          if (!seen) begin seen = 1; exp_fa = a; exp_fb = b; end
        end
    exp_cycles = 64 * (((d == 0) ? 2 : 0) + 2);

    @(negedge clk);
    start_v[d] = 1'b1;
    @(posedge clk);
    #1;
    if (!hold_start) start_v[d] = 1'b0;
    tests++;
    if (busy_v[d] !== 1'b1 || done_v[d] !== 1'b0 || pass_v[d] !== 1'b0 || err_v[d] !== 7'd0 ||
        a_v[d] !== 3'd0 || b_v[d] !== 3'd0 || fa_v[d] !== 3'd0 || fb_v[d] !== 3'd0) begin
      fails++;
      $display("FAIL %s_start_clear: busy=%b done=%b pass=%b err=%0d a=%0d b=%0d fa=%0d fb=%0d, required busy=1 rest 0",
               name, busy_v[d], done_v[d], pass_v[d], err_v[d], a_v[d], b_v[d], fa_v[d], fb_v[d]);
    end

    cycles = 0; busy_low = 0;
    while (cycles < 2000) begin
      @(posedge clk);
      cycles++;
      #1;
      if (done_v[d] === 1'b1) break;
      if (busy_v[d] !== 1'b1) busy_low++;
    end
    start_v[d] = 1'b0;

    tests++;
    if (cycles != exp_cycles) begin
      fails++;
      $display("FAIL %s_latency: got %0d cycles, required %0d", name, cycles, exp_cycles);
    end
    tests++;
    if (busy_low != 0) begin
      fails++;
      $display("FAIL %s_busy_during: busy low for %0d cycles, required 0", name, busy_low);
    end
    tests++;
    if (err_v[d] !== 7'(exp_err) || pass_v[d] !== (exp_err == 0)) begin
      fails++;
      $display("FAIL %s_result: err=%0d pass=%b, required err=%0d pass=%b",
               name, err_v[d], pass_v[d], exp_err, (exp_err == 0));
    end
    tests++;
    if (fa_v[d] !== 3'(exp_fa) || fb_v[d] !== 3'(exp_fb)) begin
      fails++;
      $display("FAIL %s_first_fail: fa=%0d fb=%0d, required fa=%0d fb=%0d",
               name, fa_v[d], fb_v[d], exp_fa, exp_fb);
    end

    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (done_v[d] !== 1'b1 || busy_v[d] !== 1'b0 || a_v[d] !== 3'd7 || b_v[d] !== 3'd7 ||
        err_v[d] !== 7'(exp_err) || fa_v[d] !== 3'(exp_fa) || fb_v[d] !== 3'(exp_fb)) begin
      fails++;
      $display("FAIL %s_done_hold: done=%b busy=%b a=%0d b=%0d err=%0d fa=%0d fb=%0d, required done=1 busy=0 a=7 b=7 err=%0d fa=%0d fb=%0d",
               name, done_v[d], busy_v[d], a_v[d], b_v[d], err_v[d], fa_v[d], fb_v[d], exp_err, exp_fa, exp_fb);
    end
  endtask

  task automatic test_correct();
    mode = 0;
    run_sweep(0, 1'b0, "correct_s2");
  endtask

  task automatic test_eq_stuck();
    mode = 1;
    run_sweep(0, 1'b0, "eq_stuck0");
  endtask

  task automatic test_gt_stuck();
    mode = 2;
    run_sweep(0, 1'b0, "gt_stuck1");
  endtask

  task automatic test_random_faults();
    mode = 3;
    for (int i = 0; i < 64; i++)
      mask[i] = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
    run_sweep(0, 1'b0, "random_faults");
    // Restart straight from DONE with the same faults: results must repeat.
    run_sweep(0, 1'b0, "random_restart");
  endtask

  task automatic test_all_fail();
    mode = 3;
    for (int i = 0; i < 64; i++) mask[i] = 6'($urandom_range(1, 63));
    run_sweep(1, 1'b0, "all_fail_s0");
  endtask

  task automatic test_mid_reset();
    int guard, done_seen;
    mode = 0;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    guard = 0;
    while (a_v[0] !== 3'd3 && guard < 1000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    tests++;
    if (a_v[0] !== 3'd3) begin
      fails++;
      $display("FAIL mid_reset_reach: a=%0d after %0d cycles, required 3", a_v[0], guard);
    end
    reset_v[0] = 1'b1;
    @(posedge clk);
    #1;
    reset_v[0] = 1'b0;
    tests++;
    if ({a_v[0], b_v[0], busy_v[0], done_v[0], pass_v[0], err_v[0], fa_v[0], fb_v[0]} !== '0) begin
      fails++;
      $display("FAIL mid_reset_clear: a=%0d b=%0d busy=%b done=%b pass=%b err=%0d, required all 0",
               a_v[0], b_v[0], busy_v[0], done_v[0], pass_v[0], err_v[0]);
    end
    done_seen = 0;
    repeat (300) begin
      @(posedge clk);
      #1;
      if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b0) done_seen++;
    end
    tests++;
    if (done_seen != 0) begin
      fails++;
      $display("FAIL mid_reset_no_done: done/busy seen %0d cycles, required 0", done_seen);
    end
    run_sweep(0, 1'b0, "after_reset");
  endtask

  task automatic test_settle0_held_start();
    mode = 0;
    run_sweep(1, 1'b1, "settle0_held_start");
  endtask

  initial begin
    start_v = '0;
    reset_v = '0;
    for (int i = 0; i < 64; i++) mask[i] = '0;
    test_reset();
    test_correct();
    test_eq_stuck();
    test_gt_stuck();
    test_random_faults();
    test_mid_reset();
    test_settle0_held_start();
    test_all_fail();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/comparator_sweep_checker.md
COMPARATOR_SWEEP_CHECKER -- requirements
Module: comparator_sweep_checker

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter: SETTLE_CYCLES, default 2, is the number of idle hold cycles before each flag sample (legal range 0-15).
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: reset  input  1  synchronous active-high reset.
REQ-005 Port: start  input  1  begins a full sweep; sampled only in IDLE or DONE.
REQ-006 Port: flags_in  input  6  comparator outputs under check, ordered {aGTb, aGEb, aLTb, aLEb, aEQb, aNEb} (bit 5 down to bit 0).
REQ-007 Port: a_out  output  3  A operand driven to the comparator.
REQ-008 Port: b_out  output  3  B operand driven to the comparator.
REQ-009 Port: busy  output  1  high while a sweep is in progress.
REQ-010 Port: done  output  1  high once a sweep completes; held until the next start or reset.
REQ-011 Port: pass  output  1  high with done when err_count is 0.
REQ-012 Port: err_count  output  7  number of mismatching operand pairs, 0-64.
REQ-013 Port: fail_a / fail_b  output  3 each  operands of the first mismatching pair; 0 if there is none.

Function
REQ-014 The FSM SHALL have the states IDLE, HOLD, CHECK and DONE.
REQ-015 IDLE or DONE with start=1 SHALL go to HOLD at the next edge:
- a_out, b_out, err_count, fail_a, fail_b and the first-fail flag are cleared.
- done and pass are cleared.
- The hold counter is loaded with SETTLE_CYCLES.
REQ-016 HOLD SHALL decrement the hold counter each cycle and go to CHECK on the cycle it reads 0; with SETTLE_CYCLES=0, HOLD lasts one cycle.
REQ-017 Each operand pair SHALL be driven for exactly SETTLE_CYCLES+2 cycles (HOLD cycles plus one CHECK cycle).
REQ-018 CHECK SHALL sample flags_in and compare it against the expected vector computed from a_out and b_out, both treated as unsigned.
REQ-019 On a mismatch in CHECK:
- err_count increments.
- If this is the first mismatch, fail_a and fail_b capture a_out and b_out.
REQ-020 Sweep order SHALL be A outer, B inner, pairs (0,0),(0,1)...(0,7),(1,0)...(7,7), 64 pairs in total.
REQ-021 After CHECK on a pair other than (7,7):
- b_out increments; from 7 it wraps to 0 and a_out increments.
- The FSM returns to HOLD with the counter reloaded.
REQ-022 After CHECK on pair (7,7), the FSM SHALL go to DONE with done=1 and pass=(err_count==0), where err_count includes the final pair's result.
REQ-023 err_count SHALL NOT wrap; 64 mismatches is the representable maximum.
REQ-024 start asserted during HOLD or CHECK SHALL be ignored.
REQ-025 busy SHALL be 1 exactly in HOLD and CHECK.
REQ-026 a_out, b_out, err_count, fail_a and fail_b SHALL hold their values in DONE.
REQ-027 A full sweep SHALL take 64*(SETTLE_CYCLES+2) cycles, counted from the edge that accepts start to the edge that sets done.

Reset
REQ-028 Reset SHALL be synchronous and active-high.
REQ-029 Reset SHALL override start.
REQ-030 Reset SHALL put the FSM in IDLE with every output 0.
REQ-031 Reset asserted mid-sweep SHALL abort the sweep with no done pulse.

Structure
REQ-032 A shared package SHALL hold:
- the FSM state enumeration;
- the flag bit-index constants GT=5, GE=4, LT=3, LE=2, EQ=1, NE=0;
- the pair-count constant 64.
REQ-033 The expected-flag computation SHALL be a combinational sub-module, comparator_ref_model: 3-bit a and b in, 6-bit flags out.
REQ-034 The implementation SHALL be the FSM and counters only, within 120-400 lines of RTL.

Verification
REQ-035 Tie flags_in to a correct comparator, SETTLE_CYCLES=2, pulse start -> done after 256 cycles, pass=1, err_count=0, fail_a=fail_b=0.
REQ-036 Force flags_in bit EQ to 0 always -> err_count=8, fail_a=0, fail_b=0, pass=0.
REQ-037 Correct comparator except aGTb stuck at 1 -> err_count=36 (all pairs with a<=b), first fail (0,0).
REQ-038 Assert reset while a_out=3 -> next cycle IDLE, all outputs 0, done never asserts; a later start performs a full sweep.
REQ-039 SETTLE_CYCLES=0 with a correct comparator -> done after 128 cycles; a start pulse held high during the sweep has no effect.
REQ-040 Start asserted again in DONE -> outputs clear and a second sweep gives identical results.
